// File: rtl/mul_param_pkg.sv
// Shared definitions for the parametrised bus multiplier: state codes,
// register map and CTRL bit positions.
package mul_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_INT_EN = 8'h01;
    localparam logic [7:0] ADDR_MODE   = 8'h02;
    localparam logic [7:0] ADDR_STATUS = 8'h03;
    localparam logic [7:0] OPA_BASE    = 8'h10;
    localparam logic [7:0] OPB_BASE    = 8'h20;
    localparam logic [7:0] RES_BASE    = 8'h30;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

endpackage

// File: rtl/mul_param_core.sv
// Iterative shift-add multiplier core: magnitude conversion, one partial
// product per cycle, final sign fix and the operation FSM.
module mul_param_core
    import mul_param_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output state_e             state_o,
    output state_e             state_next_o,
    output logic               busy_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ACC_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, mcand_q, result_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               sign_q;
    logic               load_s;

    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic as_signed);
        if (as_signed && v[WIDTH-1]) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start_i) state_d = ST_EXEC; else state_d = state_q;
                ST_EXEC:          if (cnt_q == LAST_ITER) state_d = ST_FIX; else state_d = ST_EXEC;
                ST_FIX:           state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == ST_EXEC) || (state_q == ST_FIX);
        load_s = start_i && !clear_i && !busy_o;
    end

    // Multiplicand shifts left and multiplier shifts right so each cycle
    // only inspects one multiplier bit.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            result_q <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            sign_q   <= 1'b0;
        end else if (load_s) begin
            mcand_q  <= {{WIDTH{1'b0}}, magnitude(opa_i, signed_i)};
            mplier_q <= magnitude(opb_i, signed_i);
            sign_q   <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else if (state_q == ST_EXEC) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + CNT_ONE;
        end else if (state_q == ST_FIX) begin
            result_q <= sign_q ? (~acc_q + ACC_ONE) : acc_q;
        end
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;
    assign result_o     = result_q;

endmodule

// File: rtl/mul_param_slave.sv
// Bus-slave wrapper: register file, address decode, combinational read mux
// and the level interrupt around the iterative multiplier core.
module mul_param_slave
    import mul_param_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        S_sel,
    input  logic        S_wr,
    input  logic [7:0]  S_address,
    input  logic [31:0] S_din,
    output logic [31:0] S_dout,
    output logic        m_interrupt
);
    localparam int NW = WIDTH / 32;

    state_e             core_state_s, core_state_d_s;
    logic               busy_s;
    logic [2*WIDTH-1:0] result_s;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic               int_en_q, int_en_d, mode_q, irq_q;
    logic               wr_s, start_s, clear_s;
    logic [3:0]         page_s, idx_s;
    logic [31:0]        rdata_s;

    always_comb begin
        wr_s    = S_sel && S_wr;
        page_s  = S_address[7:4];
        idx_s   = S_address[3:0];
        start_s = wr_s && (S_address == ADDR_CTRL) && S_din[CTRL_START];
        clear_s = wr_s && (S_address == ADDR_CTRL) && S_din[CTRL_CLEAR];
        if (wr_s && (S_address == ADDR_INT_EN)) int_en_d = S_din[0];
        else                                    int_en_d = int_en_q;
    end

    // Operands and mode are frozen while the core is working on them.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_en_q <= 1'b0;
            mode_q   <= 1'b0;
            irq_q    <= 1'b0;
            opa_q    <= {WIDTH{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
        end else begin
            int_en_q <= int_en_d;
            irq_q    <= int_en_d && (core_state_d_s == ST_DONE);
            if (wr_s && !busy_s) begin
                if (S_address == ADDR_MODE) mode_q <= S_din[0];
                for (int i = 0; i < NW; i++) begin
                    if (page_s == OPA_BASE[7:4] && idx_s == 4'(i)) opa_q[32*i +: 32] <= S_din;
                    if (page_s == OPB_BASE[7:4] && idx_s == 4'(i)) opb_q[32*i +: 32] <= S_din;
                end
            end
        end
    end

    always_comb begin
        rdata_s = 32'h0;
        if (S_sel && !S_wr && !reset) begin
            case (page_s)
                ADDR_CTRL[7:4]: begin
                    case (S_address)
                        ADDR_INT_EN: rdata_s = {31'h0, int_en_q};
                        ADDR_MODE:   rdata_s = {31'h0, mode_q};
                        ADDR_STATUS: rdata_s = {29'h0, busy_s, 2'(core_state_s)};
                        default:     rdata_s = 32'h0;
                    endcase
                end
                OPA_BASE[7:4]: for (int i = 0; i < NW; i++)
                    rdata_s |= (idx_s == 4'(i)) ? opa_q[32*i +: 32] : 32'h0;
                OPB_BASE[7:4]: for (int i = 0; i < NW; i++)
                    rdata_s |= (idx_s == 4'(i)) ? opb_q[32*i +: 32] : 32'h0;
                RES_BASE[7:4]: for (int j = 0; j < 2*NW; j++)
                    rdata_s |= (idx_s == 4'(j)) ? result_s[32*j +: 32] : 32'h0;
                default: rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    mul_param_core #(.WIDTH(WIDTH)) u_core (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_s),
        .clear_i      (clear_s),
        .signed_i     (mode_q),
        .opa_i        (opa_q),
        .opb_i        (opb_q),
        .state_o      (core_state_s),
        .state_next_o (core_state_d_s),
        .busy_o       (busy_s),
        .result_o     (result_s)
    );

    assign S_dout      = rdata_s;
    assign m_interrupt = irq_q;

endmodule
